// File: rtl/fifo_pkg.sv
// Shared constants for the flow-control FIFOs and their supervising FSM.
// Widths and bus positions here must agree with the FSM side.
package fifo_pkg;

    localparam int TH_W       = 5;
    localparam int FIFO_DEPTH = 16;
    localparam int FIFO_AW    = 4;
    localparam int WORD_W     = 6;

    localparam int IDX_MAIN = 0;
    localparam int IDX_VC0  = 1;
    localparam int IDX_VC1  = 2;
    localparam int IDX_D0   = 3;
    localparam int IDX_D1   = 4;

    typedef logic [TH_W-1:0] cnt_t;

    typedef enum logic [2:0] {
        FIFO_MAIN = 3'd0,
        FIFO_VC0  = 3'd1,
        FIFO_VC1  = 3'd2,
        FIFO_D0   = 3'd3,
        FIFO_D1   = 3'd4
    } fifo_id_e;

    function automatic cnt_t depth_cnt(input int d);
        return cnt_t'(d);
    endfunction

endpackage

// File: rtl/fifo_watermark_if.sv
// Data, threshold and status bundle between a FIFO and its user.
// The master side drives requests and thresholds; the slave is the FIFO.
interface fifo_watermark_if #(
    parameter int WIDTH = fifo_pkg::WORD_W
);
    import fifo_pkg::*;

    logic             wr_en;
    logic [WIDTH-1:0] data_in;
    logic             rd_en;
    cnt_t             th_low;
    cnt_t             th_high;
    logic [WIDTH-1:0] data_out;
    logic             valid_out;
    cnt_t             count;
    logic             empty;
    logic             full;
    logic             almost_empty;
    logic             almost_full;
    logic             error;

    modport master (
        output wr_en, data_in, rd_en, th_low, th_high,
        input  data_out, valid_out, count, empty, full,
        input  almost_empty, almost_full, error
    );

    modport slave (
        input  wr_en, data_in, rd_en, th_low, th_high,
        output data_out, valid_out, count, empty, full,
        output almost_empty, almost_full, error
    );

endinterface

// File: rtl/fifo_mem.sv
// Register-file storage: one synchronous write port, one registered read port.
// Array contents are deliberately left unreset; only the read register clears.
module fifo_mem #(
    parameter int WIDTH = 6,
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic             re,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata,
    output logic             rvalid
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Same-address write and read on one edge returns the old word
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rdata  <= '0;
            rvalid <= 1'b0;
        end else begin
            rvalid <= re;
            if (re) begin
                rdata <= mem[raddr];
            end
        end
    end

endmodule

// File: rtl/fifo_watermark.sv
// Synchronous FIFO with live low/high watermark flags and a sticky error.
// Occupancy is a dedicated counter so full and empty never alias.
module fifo_watermark
    import fifo_pkg::*;
#(
    parameter int WIDTH = WORD_W,
    parameter int DEPTH = FIFO_DEPTH,
    parameter int AW    = FIFO_AW
) (
    input  logic             clk,
    input  logic             reset,
    fifo_watermark_if.slave  bus
);

    localparam cnt_t DEPTH_C = depth_cnt(DEPTH);

    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    cnt_t          cnt;
    logic          err;
    logic          is_empty;
    logic          is_full;
    logic          wr_ok;
    logic          rd_ok;
    logic          bad_req;

    assign is_empty = (cnt == '0);
    assign is_full  = (cnt == DEPTH_C);

    // A full FIFO still takes a write when a read frees the slot
    assign wr_ok   = bus.wr_en && (!is_full || bus.rd_en);
    assign rd_ok   = bus.rd_en && !is_empty;
    assign bad_req = (bus.wr_en && is_full && !bus.rd_en)
                   || (bus.rd_en && is_empty);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
            err    <= 1'b0;
        end else begin
            if (wr_ok) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (rd_ok) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            unique case ({wr_ok, rd_ok})
                2'b10:   cnt <= cnt + TH_W'(1);
                2'b01:   cnt <= cnt - TH_W'(1);
                default: cnt <= cnt;
            endcase
            if (bad_req) begin
                err <= 1'b1;
            end
        end
    end

    fifo_mem #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .clk    (clk),
        .reset  (reset),
        .we     (wr_ok),
        .waddr  (wr_ptr),
        .wdata  (bus.data_in),
        .re     (rd_ok),
        .raddr  (rd_ptr),
        .rdata  (bus.data_out),
        .rvalid (bus.valid_out)
    );

    assign bus.count        = cnt;
    assign bus.empty        = is_empty;
    assign bus.full         = is_full;
    assign bus.almost_empty = (cnt <= bus.th_low);
    assign bus.almost_full  = (cnt >= bus.th_high);
    assign bus.error        = err;

endmodule

// File: tb/tb_fifo_watermark.sv
// Bench for fifo_watermark: table vectors, directed corners and random traffic
// compared against a queue-based reference model.
module tb_fifo_watermark;
    import fifo_pkg::*;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    fifo_watermark_if #(.WIDTH(WORD_W)) bus();

    fifo_watermark #(
        .WIDTH (WORD_W),
        .DEPTH (FIFO_DEPTH),
        .AW    (FIFO_AW)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int errors = 0;
    int checks = 0;

    int mq[$];
    int m_err;
    int m_valid;
    int m_dout;

    typedef struct {
        bit   wr;
        bit   rd;
        int   din;
        int   cnt;
        bit   valid;
        int   dout;
        bit   err;
    } vec_t;

    vec_t tbl[7];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic cmp_model(input string tag);
        int n;
        n = mq.size();
        chk({tag, ".count"}, 32'(bus.count), n);
        chk({tag, ".empty"}, 32'(bus.empty), 32'(n == 0));
        chk({tag, ".full"}, 32'(bus.full), 32'(n == FIFO_DEPTH));
        chk({tag, ".aempty"}, 32'(bus.almost_empty), 32'(n <= int'(bus.th_low)));
        chk({tag, ".afull"}, 32'(bus.almost_full), 32'(n >= int'(bus.th_high)));
        chk({tag, ".error"}, 32'(bus.error), m_err);
        chk({tag, ".valid"}, 32'(bus.valid_out), m_valid);
        chk({tag, ".dout"}, 32'(bus.data_out), m_dout);
    endtask

    task automatic model_step(input bit wr, input bit rd, input int din);
        bit f;
        bit e;
        f = (mq.size() == FIFO_DEPTH);
        e = (mq.size() == 0);
        m_valid = 0;
        if (rd && !e) begin
            m_dout  = mq.pop_front();
            m_valid = 1;
        end
        if (wr && (!f || rd)) mq.push_back(din);
        if ((wr && f && !rd) || (rd && e)) m_err = 1;
    endtask

    task automatic cycle(input bit wr, input bit rd, input int din,
                         input string tag);
        bus.wr_en   = wr;
        bus.rd_en   = rd;
        bus.data_in = WORD_W'(din);
        @(posedge clk);
        #1;
        model_step(wr, rd, din & 'h3F);
        cmp_model(tag);
        bus.wr_en = 1'b0;
        bus.rd_en = 1'b0;
    endtask

    // Asserts reset away from the clock edge and checks it acts at once
    task automatic do_reset();
        #2 reset = 1'b0;
        #1;
        mq.delete();
        m_err   = 0;
        m_valid = 0;
        m_dout  = 0;
        chk("rst.count", 32'(bus.count), 0);
        chk("rst.empty", 32'(bus.empty), 1);
        chk("rst.full", 32'(bus.full), 0);
        chk("rst.valid", 32'(bus.valid_out), 0);
        chk("rst.error", 32'(bus.error), 0);
        chk("rst.dout", 32'(bus.data_out), 0);
        chk("rst.aempty", 32'(bus.almost_empty), 1);
        chk("rst.afull", 32'(bus.almost_full), 32'(bus.th_high == 0));
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        cmp_model("post_rst");
    endtask

    initial begin
        bus.wr_en   = 1'b0;
        bus.rd_en   = 1'b0;
        bus.data_in = '0;
        bus.th_low  = 5'd2;
        bus.th_high = 5'd14;
        reset       = 1'b0;

        tbl = '{
            '{1'b0, 1'b1, 'h00, 0, 1'b0, 'h00, 1'b1},
            '{1'b1, 1'b1, 'h2A, 1, 1'b0, 'h00, 1'b1},
            '{1'b1, 1'b0, 'h15, 2, 1'b0, 'h00, 1'b1},
            '{1'b0, 1'b1, 'h00, 1, 1'b1, 'h2A, 1'b1},
            '{1'b1, 1'b1, 'h33, 1, 1'b1, 'h15, 1'b1},
            '{1'b0, 1'b1, 'h00, 0, 1'b1, 'h33, 1'b1},
            '{1'b0, 1'b0, 'h00, 0, 1'b0, 'h33, 1'b1}
        };

        repeat (2) @(posedge clk);
        #1;
        do_reset();
        chk("idle.aempty", 32'(bus.almost_empty), 1);
        chk("idle.afull", 32'(bus.almost_full), 0);

        // Fill to full, overflow once, drain in order
        for (int i = 0; i < 16; i++) begin
            cycle(1'b1, 1'b0, i + 1, "fill");
            chk("fill.afull", 32'(bus.almost_full), 32'(i + 1 >= 14));
            chk("fill.full", 32'(bus.full), 32'(i == 15));
        end
        chk("fill.error", 32'(bus.error), 0);
        cycle(1'b1, 1'b0, 'h3F, "ovf");
        chk("ovf.count", 32'(bus.count), 16);
        chk("ovf.error", 32'(bus.error), 1);
        cycle(1'b0, 1'b0, 0, "ovf_hold");
        chk("ovf.sticky", 32'(bus.error), 1);
        for (int i = 0; i < 16; i++) begin
            cycle(1'b0, 1'b1, 0, "drain");
            chk("drain.dout", 32'(bus.data_out), i + 1);
            chk("drain.valid", 32'(bus.valid_out), 1);
        end
        chk("drain.empty", 32'(bus.empty), 1);

        // Underflow and simultaneous request on an empty FIFO
        do_reset();
        foreach (tbl[k]) begin
            cycle(tbl[k].wr, tbl[k].rd, tbl[k].din, "tbl");
            chk("tbl.count", 32'(bus.count), tbl[k].cnt);
            chk("tbl.valid", 32'(bus.valid_out), 32'(tbl[k].valid));
            chk("tbl.dout", 32'(bus.data_out), tbl[k].dout);
            chk("tbl.error", 32'(bus.error), 32'(tbl[k].err));
        end

        // Pass-through on a full FIFO across pointer wrap
        do_reset();
        for (int i = 0; i < 16; i++) cycle(1'b1, 1'b0, i + 1, "pt_fill");
        for (int i = 0; i < 20; i++) begin
            cycle(1'b1, 1'b1, 'h11 + i, "pt");
            chk("pt.dout", 32'(bus.data_out), (i < 16) ? i + 1 : 'h11 + i - 16);
            chk("pt.count", 32'(bus.count), 16);
            chk("pt.error", 32'(bus.error), 0);
        end

        // Reset with nine words stored, then reuse
        do_reset();
        for (int i = 0; i < 9; i++) cycle(1'b1, 1'b0, 'h20 + i, "pre_rst");
        chk("pre_rst.count", 32'(bus.count), 9);
        do_reset();
        cycle(1'b1, 1'b0, 'h05, "rst_wr");
        cycle(1'b0, 1'b1, 0, "rst_rd");
        chk("rst_rd.dout", 32'(bus.data_out), 'h05);
        chk("rst_rd.valid", 32'(bus.valid_out), 1);

        // Random traffic with shifting bias and thresholds
        do_reset();
        for (int i = 0; i < 600; i++) begin
            int pw;
            int pr;
            if (i % 75 == 0) begin
                bus.th_low  = 5'($urandom_range(0, 31));
                bus.th_high = 5'($urandom_range(0, 31));
            end
            case ((i / 50) % 3)
                0:       begin pw = 80; pr = 25; end
                1:       begin pw = 20; pr = 80; end
                default: begin pw = 55; pr = 55; end
            endcase
            cycle($urandom_range(0, 99) < pw, $urandom_range(0, 99) < pr,
                  $urandom_range(0, 63), "rnd");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
